// File: rtl/accum_drain_ctrl.sv
// Drains rows from a banked accumulator. Reads are credit-limited so returns always fit the
// return buffer, the buffer feeds the output stream, and optional clear-writes zero each row read.
module accum_drain_ctrl #(
   parameter int NUM_BANKS  = 4,
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 9,
   parameter int BUF_DEPTH  = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic [ADDR_WIDTH-1:0]            base_addr,
   input  logic [ADDR_WIDTH:0]              length,
   input  logic                             clear_en,
   output logic                             busy,
   output logic                             done,
   output logic                             err,
   output logic                             rd_valid,
   output logic [ADDR_WIDTH-1:0]            rd_addr,
   output logic [NUM_BANKS-1:0]             rd_mask,
   input  logic                             rd_ready,
   input  logic                             rvalid,
   input  logic [NUM_BANKS*DATA_WIDTH-1:0]  rdata,
   output logic                             wr_valid,
   output logic [ADDR_WIDTH-1:0]            wr_addr,
   output logic [NUM_BANKS-1:0]             wr_mask,
   output logic                             accum_en,
   input  logic                             wr_ready,
   output logic                             wvalid,
   output logic [NUM_BANKS*DATA_WIDTH-1:0]  wdata,
   input  logic                             wready,
   output logic                             out_valid,
   output logic [NUM_BANKS*DATA_WIDTH-1:0]  out_data,
   output logic                             out_last,
   input  logic                             out_ready,
   output logic [1:0]                       dbg_state
);

   localparam int DW     = NUM_BANKS * DATA_WIDTH;
   localparam int CNT_W  = ADDR_WIDTH + 1;
   localparam int CRED_W = ADDR_WIDTH + 2;
   localparam int PW     = $clog2(BUF_DEPTH);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [CNT_W-1:0] CNT_ONE  = 1;
   localparam logic [PW-1:0]    PTR_ONE  = 1;
   localparam logic [PW:0]      FILL_ONE = 1;

   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [CNT_W-1:0]      length_q, length_d;
   logic                  clear_q, clear_d;
   logic                  err_q, err_d;
   logic [CNT_W-1:0]      issued_q, issued_d, received_q, received_d;
   logic [CNT_W-1:0]      emitted_q, emitted_d, cleared_q, cleared_d;
   logic [DW-1:0]         mem_q [BUF_DEPTH];
   logic [DW-1:0]         mem_d [BUF_DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]           fill_q, fill_d;

   logic                  run, rd_valid_c, wr_valid_c, out_valid_c;
   logic                  rd_fire, wr_fire, push, pop, stray, all_done;
   logic [CNT_W-1:0]      outstanding;
   logic [CRED_W-1:0]     credit;

   // Every channel uses valid/ready: a transfer happens in a cycle where both are high, valid
   // never depends on ready, and a raised valid holds its payload stable until the transfer.
   // rvalid has no ready; reads are only issued while buffer space is reserved for the return.
   always_comb begin
      run         = (state_q == ST_RUN);
      outstanding = issued_q - received_q;
      credit      = CRED_W'(outstanding) + CRED_W'(fill_q);
      rd_valid_c  = run && (issued_q < length_q) && (credit < CRED_W'(BUF_DEPTH));
      wr_valid_c  = run && clear_q && (cleared_q < received_q);
      out_valid_c = (fill_q != '0);
      rd_fire     = rd_valid_c && rd_ready;
      wr_fire     = wr_valid_c && wr_ready && wready;
      push        = run && rvalid && (issued_q != received_q);
      stray       = run && rvalid && (issued_q == received_q);
      pop         = out_valid_c && out_ready;
      all_done    = (issued_q == length_q) && (received_q == length_q) &&
                    (emitted_q == length_q) && (!clear_q || (cleared_q == length_q));
   end

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      length_d   = length_q;
      clear_d    = clear_q;
      err_d      = err_q;
      issued_d   = issued_q;
      received_d = received_q;
      emitted_d  = emitted_q;
      cleared_d  = cleared_q;
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fill_d     = fill_q;

      if (push) begin
         mem_d[wr_ptr_q] = rdata;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
         2'b10:   fill_d = fill_q + FILL_ONE;
         2'b01:   fill_d = fill_q - FILL_ONE;
         default: fill_d = fill_q;
      endcase

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               base_d     = base_addr;
               length_d   = length;
               clear_d    = clear_en;
               err_d      = 1'b0;
               issued_d   = '0;
               received_d = '0;
               emitted_d  = '0;
               cleared_d  = '0;
               wr_ptr_d   = '0;
               rd_ptr_d   = '0;
               fill_d     = '0;
               state_d    = (length == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (rd_fire) issued_d   = issued_q + CNT_ONE;
            if (push)    received_d = received_q + CNT_ONE;
            if (pop)     emitted_d  = emitted_q + CNT_ONE;
            if (wr_fire) cleared_d  = cleared_q + CNT_ONE;
            if (stray)   err_d      = 1'b1;
            if (all_done) state_d   = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         base_q     <= '0;
         length_q   <= '0;
         clear_q    <= 1'b0;
         err_q      <= 1'b0;
         issued_q   <= '0;
         received_q <= '0;
         emitted_q  <= '0;
         cleared_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fill_q     <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         length_q   <= length_d;
         clear_q    <= clear_d;
         err_q      <= err_d;
         issued_q   <= issued_d;
         received_q <= received_d;
         emitted_q  <= emitted_d;
         cleared_q  <= cleared_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fill_q     <= fill_d;
         mem_q      <= mem_d;
      end
   end

   // Row addresses wrap modulo the address space; masks and data are gated so idle outputs read 0.
   assign busy      = run;
   assign done      = (state_q == ST_DONE);
   assign err       = err_q;
   assign rd_valid  = rd_valid_c;
   assign rd_addr   = base_q + issued_q[ADDR_WIDTH-1:0];
   assign rd_mask   = {NUM_BANKS{rd_valid_c}};
   assign wr_valid  = wr_valid_c;
   assign wvalid    = wr_valid_c;
   assign wr_addr   = base_q + cleared_q[ADDR_WIDTH-1:0];
   assign wr_mask   = {NUM_BANKS{wr_valid_c}};
   assign accum_en  = 1'b0;
   assign wdata     = '0;
   assign out_valid = out_valid_c;
   assign out_data  = out_valid_c ? mem_q[rd_ptr_q] : '0;
   assign out_last  = out_valid_c && (emitted_q == length_q - CNT_ONE);
   assign dbg_state = state_q;

endmodule

// File: doc/accum_drain_ctrl.md
ACCUM_DRAIN_CTRL -- requirements
Module: accum_drain_ctrl

Interface
REQ-001 Parameter NUM_BANKS, default 4, SIMD bank count.
REQ-002 Parameter DATA_WIDTH, default 64, per-bank width.
REQ-003 Parameter ADDR_WIDTH, default 9, row address width.
REQ-004 Parameter BUF_DEPTH, default 4, read-return buffer depth, power of two, >=2.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous reset, active-high.
REQ-007 start  in  1  launch a drain; sampled only in IDLE.
REQ-008 base_addr  in  ADDR_WIDTH  first row; sampled with start.
REQ-009 length  in  ADDR_WIDTH+1  row count, 0..2^ADDR_WIDTH; sampled with start.
REQ-010 clear_en  in  1  zero each row after reading; sampled with start.
REQ-011 busy  out  1  high in RUN.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 err  out  1  sticky: read data arrived with none outstanding.
REQ-014 rd_valid / rd_addr / rd_mask  out  1 / ADDR_WIDTH / NUM_BANKS  read command to the accumulator bus slot.
REQ-015 rd_ready  in  1  read command accepted.
REQ-016 rvalid / rdata  in  1 / NUM_BANKS*DATA_WIDTH  read return; no backpressure.
REQ-017 wr_valid / wr_addr / wr_mask / accum_en  out  1 / ADDR_WIDTH / NUM_BANKS / 1  clear-write command.
REQ-018 wr_ready  in  1  write command accepted.
REQ-019 wvalid / wdata  out  1 / NUM_BANKS*DATA_WIDTH  clear-write data.
REQ-020 wready  in  1  write data accepted.
REQ-021 out_valid / out_data / out_last  out  1 / NUM_BANKS*DATA_WIDTH / 1  drained row stream.
REQ-022 out_ready  in  1  downstream accept.

Function
REQ-023 The FSM SHALL have states IDLE, RUN, DONE: IDLE->RUN on start with length>0; IDLE->DONE on start with length==0; RUN->DONE when all rows are issued, received, emitted and (if clear_en) cleared; DONE->IDLE unconditionally.
REQ-024 done SHALL be 1 exactly in DONE; start outside IDLE SHALL be ignored.
REQ-025 Counters issued, received, emitted, cleared (ADDR_WIDTH+1 bits each) SHALL clear on start.
REQ-026 rd_valid SHALL = RUN && issued<length && (issued-received)+buf_count < BUF_DEPTH, with no dependence on rd_ready.
REQ-027 rd_addr SHALL = (base_addr+issued) mod 2^ADDR_WIDTH, rd_mask all ones; issued increments on rd_valid&&rd_ready.
REQ-028 The first rd_valid SHALL appear in the cycle after start is sampled.
REQ-029 In RUN, rvalid with issued==received SHALL set err and be dropped; otherwise rdata SHALL be pushed into the buffer and received incremented.
REQ-030 The credit rule SHALL guarantee no buffer overflow; rvalid in IDLE or DONE SHALL be ignored without setting err.
REQ-031 out_valid SHALL = buffer not empty; out_data = buffer head; a row pushed in cycle N SHALL be visible no earlier than cycle N+1; one row per cycle sustained when out_ready stays high.
REQ-032 out_last SHALL be 1 when the head is row length-1; emitted increments on out_valid&&out_ready.
REQ-033 With clear_en, wr_valid and wvalid SHALL assert together while cleared<received, wr_addr=(base_addr+cleared) mod 2^ADDR_WIDTH, wr_mask all ones, accum_en=0, wdata=0.
REQ-034 A clear SHALL complete only in a cycle with wr_ready&&wready; until then all write outputs hold stable; cleared then increments.
REQ-035 Without clear_en, wr_valid and wvalid SHALL stay 0.
REQ-036 Simultaneous push and pop on a full or empty buffer SHALL be legal and keep count consistent.
REQ-037 err SHALL clear only on accepted start or reset.

Reset
REQ-038 rst SHALL force IDLE, zero all counters, empty the buffer, and drive every output 0 in the next cycle, including mid-RUN; no done pulse results.
REQ-039 After reset mid-RUN, late rvalid SHALL be ignored without err.

Verification
REQ-040 base=0x10, length=3, clear_en=0, rd_ready=1, rvalid 2 cycles after each read, out_ready=1 -> reads 0x10,0x11,0x12; three out beats, last on third; done once; no writes.
REQ-041 base=0x1FE, length=4, clear_en=1 -> reads and clears 0x1FE,0x1FF,0x000,0x001 in order, accum_en=0, wdata=0.
REQ-042 length=8, BUF_DEPTH=4, out_ready=0 -> rd_valid stops after 4 accepts; rises again one beat after out_ready=1.
REQ-043 length=0 -> done 1 cycle after start; no rd_valid, wr_valid or out_valid.
REQ-044 rvalid injected in RUN with none outstanding -> err=1, buffer unchanged; next start clears err.
REQ-045 rst asserted after 2 of 5 reads issued, then 2 rvalids -> all outputs 0, err=0, no done.
